// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-ready
// handshake, timeout abort and retired-instruction counter. All outputs come straight from flops.
module mips_control_fsm #(
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic                    c_clk,
  input  logic                    c_rst,
  input  logic                    c_i_en,
  input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
  input  logic                    c_i_mem_ready,
  output logic                    c_o_ce,
  output logic                    c_o_RegDst,
  output logic                    c_o_RegWrite,
  output logic                    c_o_ALUSrc,
  output logic                    c_o_MemRead,
  output logic                    c_o_MemWrite,
  output logic                    c_o_MemtoReg,
  output logic                    c_o_Branch,
  output logic                    c_o_Jump,
  output logic [1:0]              c_o_ALUOp,
  output logic                    c_o_illegal,
  output logic                    c_o_mem_err,
  output logic [2:0]              c_o_state,
  output logic [CNT_WIDTH-1:0]    c_o_instr_cnt
);

  localparam logic [OPCODE_WIDTH-1:0] OpR    = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OpLw   = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OpSw   = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OpBeq  = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OpAddi = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OpJ    = OPCODE_WIDTH'(6'b000010);

  localparam int unsigned    TmoW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  typedef struct packed {
    logic       ce;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctl_t;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  ctl_t                    ctl_q, ctl_d;
  logic                    illegal_q, illegal_d;
  logic                    mem_err_q, mem_err_d;
  logic                    retire;

  function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OpR) || (op == OpLw) || (op == OpSw) || (op == OpBeq) ||
           (op == OpAddi) || (op == OpJ);
  endfunction

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    mem_err_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      StIdle:   if (c_i_en) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        opcode_d = c_i_opcode;
        if (is_legal(c_i_opcode)) begin
          state_d = StExec;
        end else begin
          illegal_d = 1'b1;
          retire    = 1'b1;
        end
      end
      StExec: begin
        case (opcode_q)
          OpR, OpAddi: state_d = StWb;
          OpLw, OpSw:  state_d = StMem;
          default:     retire  = 1'b1;
        endcase
      end
      StMem: begin
        if (c_i_mem_ready) begin
          tmo_d = '0;
          if (opcode_q == OpLw) state_d = StWb;
          else                  retire  = 1'b1;
        end else if (tmo_q == TmoLast) begin
          // Abort: the access is dropped and the instruction is not counted.
          tmo_d     = '0;
          mem_err_d = 1'b1;
          state_d   = c_i_en ? StFetch : StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWb:    retire  = 1'b1;
      default: state_d = StIdle;
    endcase
    if (retire) begin
      state_d = c_i_en ? StFetch : StIdle;
      cnt_d   = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Controls for the upcoming state, so the registered outputs track state_q/opcode_q exactly.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      StFetch: ctl_d.ce = 1'b1;
      StExec: begin
        case (opcode_d)
          OpR:              ctl_d.alu_op  = 2'b10;
          OpAddi, OpLw, OpSw: ctl_d.alu_src = 1'b1;
          OpBeq: begin
            ctl_d.alu_op = 2'b01;
            ctl_d.branch = 1'b1;
          end
          OpJ:     ctl_d.jump = 1'b1;
          default: ;
        endcase
      end
      StMem: begin
        ctl_d.mem_read  = (opcode_d == OpLw);
        ctl_d.mem_write = (opcode_d == OpSw);
      end
      StWb: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.reg_dst    = (opcode_d == OpR);
        ctl_d.mem_to_reg = (opcode_d == OpLw);
      end
      default: ;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      ctl_q     <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      ctl_q     <= ctl_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign c_o_ce        = ctl_q.ce;
  assign c_o_RegDst    = ctl_q.reg_dst;
  assign c_o_RegWrite  = ctl_q.reg_write;
  assign c_o_ALUSrc    = ctl_q.alu_src;
  assign c_o_MemRead   = ctl_q.mem_read;
  assign c_o_MemWrite  = ctl_q.mem_write;
  assign c_o_MemtoReg  = ctl_q.mem_to_reg;
  assign c_o_Branch    = ctl_q.branch;
  assign c_o_Jump      = ctl_q.jump;
  assign c_o_ALUOp     = ctl_q.alu_op;
  assign c_o_illegal   = illegal_q;
  assign c_o_mem_err   = mem_err_q;
  assign c_o_state     = state_q;
  assign c_o_instr_cnt = cnt_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench: a per-instruction cycle model pushes expected outputs, a negedge monitor
// pops and compares. A second instance with a 4-bit counter exercises counter wrap.
module tb_mips_control_fsm;
  localparam int unsigned MT = 16;

  logic        c_clk = 1'b0;
  logic        c_rst, c_i_en, c_i_mem_ready;
  logic [5:0]  c_i_opcode;
  logic        c_o_ce, c_o_RegDst, c_o_RegWrite, c_o_ALUSrc, c_o_MemRead, c_o_MemWrite;
  logic        c_o_MemtoReg, c_o_Branch, c_o_Jump, c_o_illegal, c_o_mem_err;
  logic [1:0]  c_o_ALUOp;
  logic [2:0]  c_o_state;
  logic [31:0] c_o_instr_cnt;
  logic        w_ce, w_rdst, w_rw, w_asrc, w_mr, w_mw, w_m2r, w_br, w_j, w_ill, w_err;
  logic [1:0]  w_aluop;
  logic [2:0]  w_state;
  logic [3:0]  w_cnt;

  always #5 c_clk = ~c_clk;

  mips_control_fsm #(.OPCODE_WIDTH(6), .CNT_WIDTH(32), .MEM_TIMEOUT(MT)) u_dut (
    .c_clk(c_clk), .c_rst(c_rst), .c_i_en(c_i_en), .c_i_opcode(c_i_opcode),
    .c_i_mem_ready(c_i_mem_ready), .c_o_ce(c_o_ce), .c_o_RegDst(c_o_RegDst),
    .c_o_RegWrite(c_o_RegWrite), .c_o_ALUSrc(c_o_ALUSrc), .c_o_MemRead(c_o_MemRead),
    .c_o_MemWrite(c_o_MemWrite), .c_o_MemtoReg(c_o_MemtoReg), .c_o_Branch(c_o_Branch),
    .c_o_Jump(c_o_Jump), .c_o_ALUOp(c_o_ALUOp), .c_o_illegal(c_o_illegal),
    .c_o_mem_err(c_o_mem_err), .c_o_state(c_o_state), .c_o_instr_cnt(c_o_instr_cnt)
  );

  mips_control_fsm #(.OPCODE_WIDTH(6), .CNT_WIDTH(4), .MEM_TIMEOUT(MT)) u_dut_w (
    .c_clk(c_clk), .c_rst(c_rst), .c_i_en(c_i_en), .c_i_opcode(c_i_opcode),
    .c_i_mem_ready(c_i_mem_ready), .c_o_ce(w_ce), .c_o_RegDst(w_rdst),
    .c_o_RegWrite(w_rw), .c_o_ALUSrc(w_asrc), .c_o_MemRead(w_mr),
    .c_o_MemWrite(w_mw), .c_o_MemtoReg(w_m2r), .c_o_Branch(w_br),
    .c_o_Jump(w_j), .c_o_ALUOp(w_aluop), .c_o_illegal(w_ill),
    .c_o_mem_err(w_err), .c_o_state(w_state), .c_o_instr_cnt(w_cnt)
  );

  // Expected-control bit positions: {ce,RegDst,RegWrite,ALUSrc,MemRead,MemWrite,MemtoReg,
  // Branch,Jump,ALUOp[1:0],illegal,mem_err}
  localparam logic [12:0] C_CE   = 13'h1000;
  localparam logic [12:0] C_RDST = 13'h0800;
  localparam logic [12:0] C_RW   = 13'h0400;
  localparam logic [12:0] C_ASRC = 13'h0200;
  localparam logic [12:0] C_MR   = 13'h0100;
  localparam logic [12:0] C_MW   = 13'h0080;
  localparam logic [12:0] C_M2R  = 13'h0040;
  localparam logic [12:0] C_BR   = 13'h0020;
  localparam logic [12:0] C_J    = 13'h0010;
  localparam logic [12:0] C_FN   = 13'h0008;
  localparam logic [12:0] C_SUB  = 13'h0004;
  localparam logic [12:0] C_ILL  = 13'h0002;
  localparam logic [12:0] C_ERR  = 13'h0001;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  typedef struct packed {
    logic [2:0]  st;
    logic [12:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cnt_m;
  logic [12:0] pend;
  bit          idle_m;
  logic [5:0]  legal_ops[6];

  wire logic [12:0] act_ctl = {c_o_ce, c_o_RegDst, c_o_RegWrite, c_o_ALUSrc, c_o_MemRead,
                               c_o_MemWrite, c_o_MemtoReg, c_o_Branch, c_o_Jump, c_o_ALUOp,
                               c_o_illegal, c_o_mem_err};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  always @(negedge c_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state", 32'(c_o_state), 32'(e.st));
      chk("controls", 32'(act_ctl), 32'(e.ctl));
      chk("instr_cnt", c_o_instr_cnt, e.cnt);
      chk("instr_cnt_wrap4", 32'(w_cnt), 32'(e.cnt[3:0]));
    end
  end

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic ren();
    return 1'($urandom);
  endfunction

  // One clock cycle: drive inputs, record what the outputs must show during this cycle.
  task automatic step(input logic en, input logic [5:0] op, input bit op_valid, input int rdy,
                      input logic [2:0] st, input logic [12:0] ctl);
    exp_t e;
    c_i_en        = en;
    c_i_opcode    = op_valid ? op : 6'($urandom);
    c_i_mem_ready = (rdy < 0) ? 1'($urandom) : 1'(rdy);
    e.st  = st;
    e.ctl = ctl | pend;
    e.cnt = cnt_m;
    pend  = '0;
    exp_q.push_back(e);
    @(posedge c_clk);
    #1;
  endtask

  task automatic retire(input bit en);
    cnt_m  = cnt_m + 32'd1;
    idle_m = !en;
  endtask

  // Called after an edge at which c_rst was sampled high.
  task automatic reset_tail();
    cnt_m = '0;
    pend  = '0;
    step(1'b0, 6'd0, 1'b0, -1, 3'd0, 13'd0);
    c_rst  = 1'b0;
    idle_m = 1'b1;
  endtask

  // mem_wait: MEM cycle on which ready rises (0 = never); rst_at_mem: MEM cycle to reset in.
  task automatic run_instr(input logic [5:0] op, input bit en_after, input int mem_wait,
                           input int rst_at_mem);
    int n;
    logic [12:0] mctl;
    if (idle_m) begin
      repeat ($urandom % 3) step(1'b0, 6'd0, 1'b0, -1, 3'd0, 13'd0);
      step(1'b1, 6'd0, 1'b0, -1, 3'd0, 13'd0);
      idle_m = 1'b0;
    end
    step(ren(), 6'd0, 1'b0, -1, 3'd1, C_CE);
    if (!is_legal(op)) begin
      step(en_after, op, 1'b1, -1, 3'd2, 13'd0);
      retire(en_after);
      pend = pend | C_ILL;
      return;
    end
    step(ren(), op, 1'b1, -1, 3'd2, 13'd0);
    if (op == OP_R) begin
      step(ren(), 6'd0, 1'b0, -1, 3'd3, C_FN);
      step(en_after, 6'd0, 1'b0, -1, 3'd5, C_RW | C_RDST);
      retire(en_after);
    end else if (op == OP_ADDI) begin
      step(ren(), 6'd0, 1'b0, -1, 3'd3, C_ASRC);
      step(en_after, 6'd0, 1'b0, -1, 3'd5, C_RW);
      retire(en_after);
    end else if (op == OP_BEQ) begin
      step(en_after, 6'd0, 1'b0, -1, 3'd3, C_SUB | C_BR);
      retire(en_after);
    end else if (op == OP_J) begin
      step(en_after, 6'd0, 1'b0, -1, 3'd3, C_J);
      retire(en_after);
    end else begin
      step(ren(), 6'd0, 1'b0, -1, 3'd3, C_ASRC);
      mctl = (op == OP_LW) ? C_MR : C_MW;
      n = (mem_wait == 0) ? int'(MT) : mem_wait;
      for (int i = 1; i <= n; i++) begin
        if (i == rst_at_mem) begin
          c_rst = 1'b1;
          step(ren(), 6'd0, 1'b0, 0, 3'd4, mctl);
          reset_tail();
          return;
        end
        if (i == n) step(en_after, 6'd0, 1'b0, (mem_wait != 0) ? 1 : 0, 3'd4, mctl);
        else        step(ren(), 6'd0, 1'b0, 0, 3'd4, mctl);
      end
      if (mem_wait == 0) begin
        pend   = pend | C_ERR;
        idle_m = !en_after;
      end else if (op == OP_SW) begin
        retire(en_after);
      end else begin
        step(en_after, 6'd0, 1'b0, -1, 3'd5, C_RW | C_M2R);
        retire(en_after);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got no finish, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op;
    int r, w, ra;
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    c_rst = 1'b1; c_i_en = 1'b0; c_i_opcode = '0; c_i_mem_ready = 1'b0;
    cnt_m = '0; pend = '0; idle_m = 1'b1;
    @(posedge c_clk);
    #1;
    reset_tail();
    repeat (5) step(1'b0, 6'd0, 1'b0, -1, 3'd0, 13'd0);

    run_instr(OP_R, 1'b1, 0, 0);
    run_instr(OP_LW, 1'b1, 3, 0);
    run_instr(OP_SW, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_J, 1'b1, 0, 0);
    run_instr(6'b111111, 1'b1, 0, 0);
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b1, 0, 0);
    run_instr(OP_LW, 1'b1, MT, 0);
    run_instr(OP_SW, 1'b1, 0, 2);

    for (int k = 0; k < 300; k++) begin
      r = int'($urandom % 7);
      if (r < 6) begin
        op = legal_ops[r];
      end else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      r  = int'($urandom % 8);
      w  = (r == 0) ? 0 : ((r == 1) ? int'(MT) : 1 + int'($urandom % 4));
      ra = (($urandom % 40) == 0) ? 1 + int'($urandom % 3) : 0;
      run_instr(op, ($urandom % 4) != 0, w, ra);
    end

    @(negedge c_clk);
    @(negedge c_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
